pwm_multi_ch: RTL and testbench
===============================

// Module: pwm_multi_ch
// PURPOSE
//  Multi-channel PWM generator. CH_NUM outputs share one period counter.
//  Period (ARR) and per-channel compare (CCR) values are double-buffered: a load writes preload
//  registers, and they take effect only on a period boundary, so no glitched pulses occur.
//  Drives beeper/LED/motor outputs from a control FSM that programs tone and duty on the fly.
// PARAMETERS
//  CNT_W   16  width of counter, ARR and each CCR
//  CH_NUM  4   number of PWM channels (>=1)
// PORTS
//  clk_50mhz    in   1             system clock, 50 MHz
//  rst          in   1             asynchronous, active-high reset
//  en           in   1             run enable; 0 = counter cleared, outputs low
//  load         in   1             1-cycle strobe: capture arr_in/ccr_in into preload
//  arr_in       in   CNT_W         period reload value
//  ccr_in       in   CH_NUM*CNT_W  compare values; channel i = ccr_in[i*CNT_W +: CNT_W]
//  pwm          out  CH_NUM        registered PWM outputs
//  period_end   out  1             1-cycle pulse on each period boundary
//  upd_pending  out  1             preload captured, not yet transferred to active
// BEHAVIOUR
//  - Reset (async): cnt=0, arr_act=0, ccr_act[*]=0, preload=0, pwm=0, period_end=0, upd_pending=0.
//  - Edge-aligned count: while en, cnt goes 0..arr_act and then wraps to 0; period = arr_act+1 clocks.
//    Boundary cycle = en && cnt==arr_act. When arr_act==0, every enabled cycle is a boundary.
//  - pwm[i] <= en && (cnt < ccr_act[i]) (1-cycle registered latency).
//    Unsigned compare: ccr=0 gives constant low; ccr>arr_act gives constant high.
//    High time per period = min(ccr, arr_act+1).
//  - period_end <= boundary cycle (registered, so it is coincident with cnt==0 on the next cycle).
//  - Shadow update:
//    * load=1 captures arr_in/ccr_in into preload and sets upd_pending.
//    * On a boundary cycle with upd_pending, active <= preload and upd_pending clears.
//    * load on a boundary cycle: inputs go straight to active (bypass) and upd_pending stays 0.
//    * load while en=0: active updated on the next cycle and upd_pending stays 0.
//    * A second load before the boundary overwrites the preload (last write wins).
//  - en falling: next cycle cnt=0, pwm=0, period_end=0. Active, preload and pending are retained.
//    en rising: counting starts at 0 and the first period is full length.
//  - Counter arithmetic is CNT_W wide with no overflow: cnt never exceeds arr_act, because ARR
//    changes only at a boundary.
//  - Reset mid-period: all state returns to reset values immediately; a pending update is discarded.
// CONFIGURATION
//  PWM_CENTER_ALIGN_EN
//  - Defined: adds input center (1 bit). center=1 selects an up/down counter with a direction flag:
//    * Up phase 0..arr_act, then down phase arr_act-1..0. Period = 2*arr_act clocks (arr_act>=1).
//    * Boundary = down phase && cnt==1 (next cnt=0, direction up). arr_act==0 holds cnt=0 and
//      every cycle is a boundary.
//    * pwm uses the same compare and is high for 2*ccr-1 clocks, centred on cnt==0.
//      ccr>arr_act gives constant high.
//    * center is sampled only at a boundary or while en=0. A change mid-period takes effect at the
//      next boundary.
//  - Undefined: no center port; edge-aligned only.
// TESTING
//  1. Reset, en=1, load arr=9, ccr0=3, ccr1=0, ccr2=10, ccr3=5 while en=0 -> period 10 clk;
//     ch0 high 3, ch1 always low, ch2 always high, ch3 high 5; period_end every 10 clk.
//  2. Mid-period (cnt=4) load arr=4, ccr0=2 -> upd_pending=1; current period finishes at 10 clk;
//     next periods 5 clk with ch0 high 2; pending clears at boundary.
//  3. Load on the boundary cycle -> new values in the very next period and upd_pending never asserts;
//     two loads in one period -> only the second takes effect.
//  4. en dropped at cnt=6 -> pwm=0 and cnt=0 next cycle; en restored -> full first period,
//     no runt pulse.
//  5. rst asserted mid-period with pending update -> all outputs 0 asynchronously; after release
//     outputs stay low until a new load.
//  6. (PWM_CENTER_ALIGN_EN) center=1, arr=8, ccr0=3 -> period 16 clk, ch0 high 5 clk centred on
//     cnt=0, period_end once per 16 clk.

Source files
------------

// File: rtl/pwm_multi_ch.sv
// Multi-channel PWM generator: one shared period counter, double-buffered ARR/CCR.
// Optional macro PWM_CENTER_ALIGN_EN adds a 'center' input for up/down (centre-aligned) counting.
module pwm_multi_ch #(
    parameter int CNT_W  = 16,
    parameter int CH_NUM = 4
) (
    input  logic                    clk_50mhz,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    load,
    input  logic [CNT_W-1:0]        arr_in,
    input  logic [CH_NUM*CNT_W-1:0] ccr_in,
`ifdef PWM_CENTER_ALIGN_EN
    input  logic                    center,
`endif
    output logic [CH_NUM-1:0]       pwm,
    output logic                    period_end,
    output logic                    upd_pending
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [CNT_W-1:0]        arr_act_q, arr_act_d;
    logic [CNT_W-1:0]        arr_pre_q, arr_pre_d;
    logic [CH_NUM*CNT_W-1:0] ccr_act_q, ccr_act_d;
    logic [CH_NUM*CNT_W-1:0] ccr_pre_q, ccr_pre_d;
    logic                    pend_q, pend_d;
    logic [CH_NUM-1:0]       pwm_q, pwm_d;
    logic                    pe_q, pe_d;
    logic                    boundary;

`ifdef PWM_CENTER_ALIGN_EN
    typedef enum logic {DIR_UP, DIR_DOWN} dir_e;
    dir_e dir_q, dir_d;
    logic center_q, center_d;
`endif

    // Counter sequencing; boundary marks the last cycle of a period.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        cnt_d    = cnt_q;
        boundary = 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
        dir_d    = dir_q;
`endif
        if (!en) begin
            cnt_d = '0;
`ifdef PWM_CENTER_ALIGN_EN
            dir_d = DIR_UP;
`endif
        end
`ifdef PWM_CENTER_ALIGN_EN
        else if (center_q) begin
            if (arr_act_q == '0) begin
                boundary = 1'b1;
                cnt_d    = '0;
                dir_d    = DIR_UP;
            end else if (cnt_q == CNT_ONE && (dir_q == DIR_DOWN || arr_act_q == CNT_ONE)) begin
                // arr_act==1 turns around straight into 0, so the top is also the boundary.
                boundary = 1'b1;
                cnt_d    = '0;
                dir_d    = DIR_UP;
            end else if (dir_q == DIR_UP) begin
                if (cnt_q == arr_act_q) begin
                    dir_d = DIR_DOWN;
                    cnt_d = cnt_q - CNT_ONE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end else begin
                cnt_d = cnt_q - CNT_ONE;
            end
        end
`endif
        else if (cnt_q == arr_act_q) begin
            boundary = 1'b1;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // Shadow registers: a load on a boundary or while idle bypasses the preload stage.
    always_comb begin
        arr_act_d = arr_act_q;
        ccr_act_d = ccr_act_q;
        arr_pre_d = arr_pre_q;
        ccr_pre_d = ccr_pre_q;
        pend_d    = pend_q;
        if (load) begin
            arr_pre_d = arr_in;
            ccr_pre_d = ccr_in;
            if (boundary || !en) begin
                arr_act_d = arr_in;
                ccr_act_d = ccr_in;
                pend_d    = 1'b0;
            end else begin
                pend_d    = 1'b1;
            end
        end else if (boundary && pend_q) begin
            arr_act_d = arr_pre_q;
            ccr_act_d = ccr_pre_q;
            pend_d    = 1'b0;
        end
    end

    always_comb begin
        pwm_d = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            pwm_d[i] = en && (cnt_q < ccr_act_q[i*CNT_W +: CNT_W]);
        end
        pe_d = boundary;
    end

`ifdef PWM_CENTER_ALIGN_EN
    // Mode changes only between periods so a running period is never distorted.
    always_comb begin
        center_d = center_q;
        if (boundary || !en) begin
            center_d = center;
        end
    end
`endif

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clk_50mhz or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            arr_act_q <= '0;
            arr_pre_q <= '0;
            ccr_act_q <= '0;
            ccr_pre_q <= '0;
            pend_q    <= 1'b0;
            pwm_q     <= '0;
            pe_q      <= 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
            dir_q     <= DIR_UP;
            center_q  <= 1'b0;
`endif
        end else begin
            cnt_q     <= cnt_d;
            arr_act_q <= arr_act_d;
            arr_pre_q <= arr_pre_d;
            ccr_act_q <= ccr_act_d;
            ccr_pre_q <= ccr_pre_d;
            pend_q    <= pend_d;
            pwm_q     <= pwm_d;
            pe_q      <= pe_d;
`ifdef PWM_CENTER_ALIGN_EN
            dir_q     <= dir_d;
            center_q  <= center_d;
`endif
        end
    end

    assign pwm         = pwm_q;
    assign period_end  = pe_q;
    assign upd_pending = pend_q;

endmodule

// File: tb/tb_pwm_multi_ch.sv
// Self-checking bench for pwm_multi_ch: directed scenarios plus randomized traffic against
// a period-position model (build with PWM_CENTER_ALIGN_EN to cover centre-aligned mode).
module tb_pwm_multi_ch;

    localparam int CNT_W = 16;
    localparam int CH    = 4;

    logic                clk_50mhz = 1'b0;
    logic                rst       = 1'b1;
    logic                en        = 1'b0;
    logic                load      = 1'b0;
    logic [CNT_W-1:0]    arr_in    = '0;
    logic [CH*CNT_W-1:0] ccr_in    = '0;
    logic                center_s  = 1'b0;
    logic [CH-1:0]       pwm;
    logic                period_end;
    logic                upd_pending;

    int n_cmp = 0;
    int n_mis = 0;

    always #10 clk_50mhz = ~clk_50mhz;

    pwm_multi_ch #(.CNT_W(CNT_W), .CH_NUM(CH)) dut (
        .clk_50mhz  (clk_50mhz),
        .rst        (rst),
        .en         (en),
        .load       (load),
        .arr_in     (arr_in),
        .ccr_in     (ccr_in),
`ifdef PWM_CENTER_ALIGN_EN
        .center     (center_s),
`endif
        .pwm        (pwm),
        .period_end (period_end),
        .upd_pending(upd_pending)
    );

    // Reference model: position inside the current period plus active/preload settings.
    int          m_pos;
    int          m_arr;
    int          m_parr;
    int          m_ccr[CH];
    int          m_pccr[CH];
    bit          m_pend;
    bit          m_cen;
    logic [CH-1:0] e_pwm;
    logic        e_pe;
    logic        e_pend;

    task automatic model_reset();
        m_pos = 0; m_arr = 0; m_parr = 0; m_pend = 0; m_cen = 0;
        for (int i = 0; i < CH; i++) begin
            m_ccr[i] = 0; m_pccr[i] = 0;
        end
        e_pwm = '0; e_pe = 1'b0; e_pend = 1'b0;
    endtask

    task automatic model_step();
        int len, cnt;
        bit bnd;
        if (m_cen) len = (m_arr == 0) ? 1 : 2 * m_arr;
        else       len = m_arr + 1;
        cnt = (m_cen && m_pos > m_arr) ? 2 * m_arr - m_pos : m_pos;
        bnd = en && (m_pos == len - 1);
        for (int i = 0; i < CH; i++) e_pwm[i] = en && (cnt < m_ccr[i]);
        e_pe  = bnd;
        m_pos = (en && !bnd) ? m_pos + 1 : 0;
        if (bnd || !en) m_cen = center_s;
        if (load) begin
            m_parr = int'(arr_in);
            for (int i = 0; i < CH; i++) m_pccr[i] = int'(ccr_in[i*CNT_W +: CNT_W]);
            if (bnd || !en) begin
                m_arr = m_parr;
                for (int i = 0; i < CH; i++) m_ccr[i] = m_pccr[i];
                m_pend = 0;
            end else begin
                m_pend = 1;
            end
        end else if (bnd && m_pend) begin
            m_arr = m_parr;
            for (int i = 0; i < CH; i++) m_ccr[i] = m_pccr[i];
            m_pend = 0;
        end
        e_pend = m_pend;
    endtask

    // One clock: inputs already set at the negedge, sample outputs at the next negedge.
    task automatic step();
        @(posedge clk_50mhz);
        model_step();
        @(negedge clk_50mhz);
    endtask

    task automatic do_load(input int a, input int c0, input int c1, input int c2, input int c3);
        arr_in = CNT_W'(a);
        ccr_in = {CNT_W'(c3), CNT_W'(c2), CNT_W'(c1), CNT_W'(c0)};
        load   = 1'b1;
        step();
        load   = 1'b0;
    endtask

    task automatic wait_pos(input int p);
        for (int k = 0; k < 64 && m_pos != p; k++) step();
    endtask

    task automatic wait_period_end(output bit found);
        found = 1'b0;
        for (int k = 0; k < 64 && !found; k++) begin
            step();
            found = (period_end === 1'b1);
        end
    endtask

    int          hi_cnt[CH];
    int          pe_cnt;
    bit          saw_pend;
    bit          last_pe;
    logic [31:0] pat;

    task automatic measure(input int n);
        for (int i = 0; i < CH; i++) hi_cnt[i] = 0;
        pe_cnt = 0; saw_pend = 1'b0; last_pe = 1'b0; pat = '0;
        for (int k = 0; k < n; k++) begin
            step();
            for (int i = 0; i < CH; i++) if (pwm[i] === 1'b1) hi_cnt[i]++;
            if (period_end === 1'b1) pe_cnt++;
            if (upd_pending !== 1'b0) saw_pend = 1'b1;
            pat[k]  = pwm[0];
            last_pe = (period_end === 1'b1);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        model_reset();
        @(negedge clk_50mhz);
        n_cmp++; if (pwm !== 4'b0) begin n_mis++; $display("FAIL reset_pwm: got %b expected 0000", pwm); end
        n_cmp++; if (period_end !== 1'b0) begin n_mis++; $display("FAIL reset_period_end: got %b expected 0", period_end); end
        n_cmp++; if (upd_pending !== 1'b0) begin n_mis++; $display("FAIL reset_pending: got %b expected 0", upd_pending); end
        rst = 1'b0;
        step();
        n_cmp++; if (pwm !== 4'b0) begin n_mis++; $display("FAIL idle_pwm: got %b expected 0000", pwm); end
    endtask

    task automatic test_basic();
        int exp_hi[CH] = '{3, 0, 10, 5};
        bit found;
        en = 1'b0;
        do_load(9, 3, 0, 10, 5);
        n_cmp++; if (upd_pending !== 1'b0) begin n_mis++; $display("FAIL basic_idle_load_pending: got %b expected 0", upd_pending); end
        en = 1'b1;
        wait_period_end(found);
        n_cmp++; if (!found) begin n_mis++; $display("FAIL basic_period_end_seen: got 0 expected 1"); end
        measure(10);
        for (int i = 0; i < CH; i++) begin
            n_cmp++; if (hi_cnt[i] != exp_hi[i]) begin n_mis++; $display("FAIL basic_high_ch%0d: got %0d expected %0d", i, hi_cnt[i], exp_hi[i]); end
        end
        n_cmp++; if (pe_cnt != 1 || !last_pe) begin n_mis++; $display("FAIL basic_period_10: got count %0d last %0d expected 1 1", pe_cnt, last_pe); end
        n_cmp++; if (pat[9:0] !== 10'h007) begin n_mis++; $display("FAIL basic_ch0_shape: got %h expected 007", pat[9:0]); end
    endtask

    task automatic test_midperiod_load();
        int exp_hi[CH] = '{2, 0, 5, 5};
        int k;
        wait_pos(4);
        do_load(4, 2, 0, 10, 5);
        n_cmp++; if (upd_pending !== 1'b1) begin n_mis++; $display("FAIL mid_pending_set: got %b expected 1", upd_pending); end
        k = 0;
        while (k < 20 && period_end !== 1'b1) begin step(); k++; end
        n_cmp++; if (k != 5) begin n_mis++; $display("FAIL mid_old_period_finish: got %0d cycles expected 5", k); end
        n_cmp++; if (upd_pending !== 1'b0) begin n_mis++; $display("FAIL mid_pending_clear: got %b expected 0", upd_pending); end
        measure(5);
        for (int i = 0; i < CH; i++) begin
            n_cmp++; if (hi_cnt[i] != exp_hi[i]) begin n_mis++; $display("FAIL mid_high_ch%0d: got %0d expected %0d", i, hi_cnt[i], exp_hi[i]); end
        end
        n_cmp++; if (pe_cnt != 1 || !last_pe) begin n_mis++; $display("FAIL mid_period_5: got count %0d last %0d expected 1 1", pe_cnt, last_pe); end
    endtask

    task automatic test_boundary_load();
        int exp_a[CH] = '{1, 0, 7, 5};
        int exp_b[CH] = '{2, 0, 6, 5};
        bit found;
        wait_pos(4);
        do_load(6, 1, 0, 10, 5);
        n_cmp++; if (upd_pending !== 1'b0 || period_end !== 1'b1) begin n_mis++; $display("FAIL bnd_load_bypass: got pend %b pe %b expected 0 1", upd_pending, period_end); end
        measure(7);
        for (int i = 0; i < CH; i++) begin
            n_cmp++; if (hi_cnt[i] != exp_a[i]) begin n_mis++; $display("FAIL bnd_high_ch%0d: got %0d expected %0d", i, hi_cnt[i], exp_a[i]); end
        end
        n_cmp++; if (pe_cnt != 1 || !last_pe || saw_pend) begin n_mis++; $display("FAIL bnd_period_7: got count %0d last %0d pend %0d expected 1 1 0", pe_cnt, last_pe, saw_pend); end
        wait_pos(2);
        do_load(3, 3, 0, 10, 5);
        wait_pos(4);
        do_load(5, 2, 0, 10, 5);
        wait_period_end(found);
        n_cmp++; if (!found) begin n_mis++; $display("FAIL dbl_period_end_seen: got 0 expected 1"); end
        measure(6);
        for (int i = 0; i < CH; i++) begin
            n_cmp++; if (hi_cnt[i] != exp_b[i]) begin n_mis++; $display("FAIL dbl_high_ch%0d: got %0d expected %0d", i, hi_cnt[i], exp_b[i]); end
        end
        n_cmp++; if (pe_cnt != 1 || !last_pe) begin n_mis++; $display("FAIL dbl_period_6: got count %0d last %0d expected 1 1", pe_cnt, last_pe); end
    endtask

    task automatic test_en_toggle();
        int exp_hi[CH] = '{3, 0, 10, 5};
        bit found;
        do_load(9, 3, 0, 10, 5);
        wait_period_end(found);
        n_cmp++; if (!found) begin n_mis++; $display("FAIL en_period_end_seen: got 0 expected 1"); end
        wait_pos(6);
        en = 1'b0;
        step();
        n_cmp++; if (pwm !== 4'b0 || period_end !== 1'b0) begin n_mis++; $display("FAIL en_drop: got pwm %b pe %b expected 0000 0", pwm, period_end); end
        for (int k = 0; k < 3; k++) begin
            step();
            n_cmp++; if (pwm !== 4'b0) begin n_mis++; $display("FAIL en_idle_pwm: got %b expected 0000", pwm); end
        end
        en = 1'b1;
        measure(10);
        for (int i = 0; i < CH; i++) begin
            n_cmp++; if (hi_cnt[i] != exp_hi[i]) begin n_mis++; $display("FAIL en_restart_ch%0d: got %0d expected %0d", i, hi_cnt[i], exp_hi[i]); end
        end
        n_cmp++; if (pe_cnt != 1 || !last_pe || pat[9:0] !== 10'h007) begin n_mis++; $display("FAIL en_full_first_period: got count %0d last %0d shape %h expected 1 1 007", pe_cnt, last_pe, pat[9:0]); end
    endtask

    task automatic test_reset_mid();
        wait_pos(3);
        do_load(2, 1, 1, 1, 1);
        n_cmp++; if (upd_pending !== 1'b1 || pwm[2] !== 1'b1) begin n_mis++; $display("FAIL rstmid_pre: got pend %b pwm %b expected 1 x1xx", upd_pending, pwm); end
        #5 rst = 1'b1;
        #1;
        n_cmp++; if (pwm !== 4'b0 || period_end !== 1'b0 || upd_pending !== 1'b0) begin n_mis++; $display("FAIL rstmid_async: got pwm %b pe %b pend %b expected all 0", pwm, period_end, upd_pending); end
        @(negedge clk_50mhz);
        @(negedge clk_50mhz);
        rst = 1'b0;
        model_reset();
        for (int k = 0; k < 6; k++) begin
            step();
            n_cmp++; if (pwm !== 4'b0 || upd_pending !== 1'b0) begin n_mis++; $display("FAIL rstmid_stays_low: got pwm %b pend %b expected 0000 0", pwm, upd_pending); end
            n_cmp++; if (period_end !== e_pe) begin n_mis++; $display("FAIL rstmid_period_end: got %b expected %b", period_end, e_pe); end
        end
    endtask

`ifdef PWM_CENTER_ALIGN_EN
    task automatic test_center();
        int exp_hi[CH] = '{5, 0, 16, 15};
        bit found;
        en = 1'b0;
        center_s = 1'b1;
        do_load(8, 3, 0, 9, 8);
        en = 1'b1;
        wait_period_end(found);
        n_cmp++; if (!found) begin n_mis++; $display("FAIL ctr_period_end_seen: got 0 expected 1"); end
        measure(16);
        for (int i = 0; i < CH; i++) begin
            n_cmp++; if (hi_cnt[i] != exp_hi[i]) begin n_mis++; $display("FAIL ctr_high_ch%0d: got %0d expected %0d", i, hi_cnt[i], exp_hi[i]); end
        end
        n_cmp++; if (pe_cnt != 1 || !last_pe) begin n_mis++; $display("FAIL ctr_period_16: got count %0d last %0d expected 1 1", pe_cnt, last_pe); end
        n_cmp++; if (pat[15:0] !== 16'hC007) begin n_mis++; $display("FAIL ctr_ch0_centred: got %h expected c007", pat[15:0]); end
    endtask
`endif

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            en     = ($urandom_range(0, 19) != 0);
            load   = ($urandom_range(0, 7) == 0);
            arr_in = CNT_W'($urandom_range(0, 12));
            for (int i = 0; i < CH; i++) ccr_in[i*CNT_W +: CNT_W] = CNT_W'($urandom_range(0, 14));
`ifdef PWM_CENTER_ALIGN_EN
            if ($urandom_range(0, 15) == 0) center_s = ~center_s;
`endif
            step();
            n_cmp++; if (pwm !== e_pwm) begin n_mis++; $display("FAIL rand_pwm @%0d: got %b expected %b", c, pwm, e_pwm); end
            n_cmp++; if (period_end !== e_pe) begin n_mis++; $display("FAIL rand_period_end @%0d: got %b expected %b", c, period_end, e_pe); end
            n_cmp++; if (upd_pending !== e_pend) begin n_mis++; $display("FAIL rand_pending @%0d: got %b expected %b", c, upd_pending, e_pend); end
        end
        load = 1'b0;
    endtask

    initial begin
        #(20 * 60000);
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_midperiod_load();
        test_boundary_load();
        test_en_toggle();
        test_reset_mid();
`ifdef PWM_CENTER_ALIGN_EN
        test_center();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
